// File: rtl/mmu_text_arbiter_if.sv
// CPU-side bus of the text-mode memory manager: request, store data, load data and done pulse.
interface mmu_text_arbiter_if #(
    parameter int ADDR_W = 15
) ();
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_read;
    logic              cpu_write;
    logic              cpu_half;
    logic [31:0]       cpu_wdata;
    logic              cpu_cs;
    logic [31:0]       cpu_rdata;
    logic              cpu_ok;

    modport master (
        output cpu_addr, cpu_read, cpu_write, cpu_half, cpu_wdata, cpu_cs,
        input  cpu_rdata, cpu_ok
    );

    modport slave (
        input  cpu_addr, cpu_read, cpu_write, cpu_half, cpu_wdata, cpu_cs,
        output cpu_rdata, cpu_ok
    );
endinterface

// File: rtl/mmu_text_arbiter.sv
// Single-port RAM arbiter: text-mode character prefetch (priority) against CPU word/halfword
// accesses, with hardware row scrolling and sticky display-underrun detection.
module mmu_text_arbiter #(
    parameter int                ADDR_W      = 15,
    parameter int                COLS        = 40,
    parameter int                ROWS        = 25,
    parameter int                CW_LOG2     = 4,
    parameter int                CH_LOG2     = 4,
    parameter logic [ADDR_W-1:0] SCREEN_BASE = ADDR_W'(15'h3000),
    parameter int                FETCH_PHASE = 10,
    localparam int               ROW_W       = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    mmu_text_arbiter_if.slave cpu,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic [ROW_W-1:0]  scroll_row,
    output logic [ADDR_W-2:0] ram_addr,
    output logic [1:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [15:0]       disp_code,
    output logic              underrun
);

    typedef enum logic [1:0] {IDLE, DISP_RD, CPU_RD} state_t;

    state_t            state, state_next;
    logic [ROW_W-1:0]  scroll;
    logic              disp_pend;
    logic [ADDR_W-1:0] fetch_addr;
    logic              disp_sel;
    logic              rd_half;
    logic              rd_sel;
    logic [15:0]       code_next;
    logic [31:0]       cpu_rdata_q;
    logic              cpu_ok_q;

    logic [9:0]         col, row, col_nxt, row_nxt, phys_sum, phys_row;
    logic [CW_LOG2-1:0] px;
    logic [CH_LOG2-1:0] py;
    logic [15:0]        cell_idx;
    logic [ADDR_W-1:0]  fetch_target;
    logic               fetch_req, disp_load, cpu_req;
    logic               fetch_issue, cpu_wr_acc, cpu_rd_acc;

    assign col       = xpos >> CW_LOG2;
    assign row       = ypos >> CH_LOG2;
    assign px        = xpos[CW_LOG2-1:0];
    assign py        = ypos[CH_LOG2-1:0];
    assign fetch_req = pix_valid && (px == CW_LOG2'(FETCH_PHASE));
    assign disp_load = pix_valid && (&px);
    assign cpu_req   = cpu.cpu_cs && (cpu.cpu_read || cpu.cpu_write);

    // The prefetch targets the cell after the current one, wrapping at line and screen end.
    always_comb begin
        col_nxt = col + 10'd1;
        row_nxt = row;
        if (col == 10'(COLS - 1)) begin
            col_nxt = '0;
            if (&py) begin
                row_nxt = (row == 10'(ROWS - 1)) ? '0 : row + 10'd1;
            end
        end
    end

    assign phys_sum     = row_nxt + 10'(scroll);
    assign phys_row     = (phys_sum >= 10'(ROWS)) ? phys_sum - 10'(ROWS) : phys_sum;
    assign cell_idx     = 16'(phys_row) * 16'(COLS) + 16'(col_nxt);
    assign fetch_target = SCREEN_BASE + ADDR_W'(cell_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Display fetch wins over the CPU; writes finish in the accept cycle without leaving IDLE.
    always_comb begin
        state_next  = state;
        ram_addr    = cpu.cpu_addr[ADDR_W-1:1];
        ram_we      = 2'b00;
        ram_wdata   = cpu.cpu_half ? {2{cpu.cpu_wdata[15:0]}} : cpu.cpu_wdata;
        fetch_issue = 1'b0;
        cpu_wr_acc  = 1'b0;
        cpu_rd_acc  = 1'b0;
        case (state)
            IDLE: begin
                if (disp_pend) begin
                    ram_addr    = fetch_addr[ADDR_W-1:1];
                    fetch_issue = 1'b1;
                    state_next  = DISP_RD;
                end else if (cpu_req && !cpu_ok_q) begin
                    if (cpu.cpu_write) begin
                        cpu_wr_acc = 1'b1;
                        if (!cpu.cpu_half) begin
                            ram_we = 2'b11;
                        end else begin
                            ram_we = cpu.cpu_addr[0] ? 2'b10 : 2'b01;
                        end
                    end else begin
                        cpu_rd_acc = 1'b1;
                        state_next = CPU_RD;
                    end
                end
            end
            DISP_RD: state_next = IDLE;
            CPU_RD:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) begin
            ram_we = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scroll      <= '0;
            disp_pend   <= 1'b0;
            fetch_addr  <= '0;
            disp_sel    <= 1'b0;
            rd_half     <= 1'b0;
            rd_sel      <= 1'b0;
            code_next   <= '0;
            cpu_rdata_q <= '0;
            cpu_ok_q    <= 1'b0;
            disp_code   <= '0;
            underrun    <= 1'b0;
        end else begin
            if (frame_start) begin
                scroll <= scroll_row;
            end
            if (fetch_req) begin
                disp_pend  <= 1'b1;
                fetch_addr <= fetch_target;
            end else if (fetch_issue) begin
                disp_pend <= 1'b0;
            end
            if (fetch_issue) begin
                disp_sel <= fetch_addr[0];
            end
            if (cpu_rd_acc) begin
                rd_half <= cpu.cpu_half;
                rd_sel  <= cpu.cpu_addr[0];
            end
            cpu_ok_q <= cpu_wr_acc || (state == CPU_RD);
            if (state == CPU_RD) begin
                if (rd_half) begin
                    cpu_rdata_q <= {16'h0000, rd_sel ? ram_rdata[31:16] : ram_rdata[15:0]};
                end else begin
                    cpu_rdata_q <= ram_rdata;
                end
            end
            if (state == DISP_RD) begin
                code_next <= disp_sel ? ram_rdata[31:16] : ram_rdata[15:0];
            end
            // A fetch still outstanding at the cell boundary means code_next is stale.
            if (disp_load) begin
                if (disp_pend || fetch_req || (state == DISP_RD)) begin
                    underrun <= 1'b1;
                end else begin
                    disp_code <= code_next;
                end
            end
        end
    end

    assign cpu.cpu_rdata = cpu_rdata_q;
    assign cpu.cpu_ok    = cpu_ok_q;

endmodule
